// File: rtl/interrupt_sequencer_pkg.sv
// Shared 6801 core types: bus address classes, data-out selects, exception
// sequencer states and the interrupt vector indices.
package interrupt_sequencer_pkg;

  typedef enum logic [2:0] {
    idle_ad,
    fetch_ad,
    read_ad,
    write_ad,
    push_ad,
    pull_ad,
    int_hi_ad,
    int_lo_ad
  } addr_type;

  typedef enum logic [2:0] {
    md_lo_dout,
    pc_lo_dout,
    pc_hi_dout,
    ix_lo_dout,
    ix_hi_dout,
    acca_dout,
    accb_dout,
    cc_dout
  } dout_type;

  typedef enum logic [3:0] {
    IDLE,
    P_PCL,
    P_PCH,
    P_IXL,
    P_IXH,
    P_A,
    P_B,
    P_CC,
    WAIT,
    V_HI,
    V_LO,
    DONE
  } istate_type;

  // Vector index: address is {12'hFFF, index, lo_byte}.
  localparam logic [2:0] SCI_VEC   = 3'd0;
  localparam logic [2:0] TOF_VEC   = 3'd1;
  localparam logic [2:0] OCF_VEC   = 3'd2;
  localparam logic [2:0] ICF_VEC   = 3'd3;
  localparam logic [2:0] IRQ1_VEC  = 3'd4;
  localparam logic [2:0] SWI_VEC   = 3'd5;
  localparam logic [2:0] NMI_VEC   = 3'd6;
  localparam logic [2:0] RESET_VEC = 3'd7;

endpackage

// File: rtl/interrupt_sequencer.sv
// 6801 exception entry sequencer: stacks PC/IX/A/B/CCR, optionally parks for
// WAI, then fetches the two vector bytes.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [2:0] RESET_IV = RESET_VEC,
  parameter logic [2:0] NMI_IV   = NMI_VEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] start_iv,
  input  logic       wai_mode,
  input  logic       wake,
  input  logic [2:0] wake_iv,
  input  logic       stall,
  output addr_type   addr_ctrl,
  output logic [2:0] iv,
  output dout_type   dout_sel,
  output logic       sp_dec,
  output logic       pc_hi_load,
  output logic       pc_lo_load,
  output logic       set_i,
  output logic       busy,
  output logic       done
);

  if (RESET_IV == NMI_IV) begin : g_iv_clash
    $error("RESET_IV and NMI_IV must differ");
  end

  istate_type state;
  logic [2:0] iv_reg;
  logic       wai_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      iv_reg  <= '0;
      wai_reg <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            iv_reg  <= start_iv;
            wai_reg <= wai_mode;
            state   <= (start_iv == RESET_IV) ? V_HI : P_PCL;
          end
        end
        P_PCL: state <= P_PCH;
        P_PCH: state <= P_IXL;
        P_IXL: state <= P_IXH;
        P_IXH: state <= P_A;
        P_A:   state <= P_B;
        P_B:   state <= P_CC;
        P_CC:  state <= wai_reg ? WAIT : V_HI;
        WAIT: begin
          if (wake) begin
            iv_reg <= wake_iv;
            state  <= V_HI;
          end
        end
        V_HI:    state <= V_LO;
        V_LO:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic push_st;
  logic hi_st;
  logic lo_st;
  logic done_st;

  // Strobes are masked by stall so each fires once, on the advancing cycle.
  always_comb begin
    addr_ctrl = idle_ad;
    dout_sel  = md_lo_dout;
    push_st   = 1'b0;
    hi_st     = 1'b0;
    lo_st     = 1'b0;
    done_st   = 1'b0;
    unique case (state)
      P_PCL: begin addr_ctrl = push_ad; dout_sel = pc_lo_dout; push_st = 1'b1; end
      P_PCH: begin addr_ctrl = push_ad; dout_sel = pc_hi_dout; push_st = 1'b1; end
      P_IXL: begin addr_ctrl = push_ad; dout_sel = ix_lo_dout; push_st = 1'b1; end
      P_IXH: begin addr_ctrl = push_ad; dout_sel = ix_hi_dout; push_st = 1'b1; end
      P_A:   begin addr_ctrl = push_ad; dout_sel = acca_dout;  push_st = 1'b1; end
      P_B:   begin addr_ctrl = push_ad; dout_sel = accb_dout;  push_st = 1'b1; end
      P_CC:  begin addr_ctrl = push_ad; dout_sel = cc_dout;    push_st = 1'b1; end
      V_HI:  begin addr_ctrl = int_hi_ad; hi_st = 1'b1; end
      V_LO:  begin addr_ctrl = int_lo_ad; lo_st = 1'b1; end
      DONE:  done_st = 1'b1;
      default: ;
    endcase
    sp_dec     = push_st & ~stall;
    pc_hi_load = hi_st & ~stall;
    set_i      = hi_st & ~stall;
    pc_lo_load = lo_st & ~stall;
    done       = done_st & ~stall;
    busy       = (state != IDLE);
  end

  assign iv = iv_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: per-cycle expected output vectors
// are queued from the documented timelines and compared as the DUT steps.
module tb_interrupt_sequencer;
  import interrupt_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] start_iv;
  logic       wai_mode;
  logic       wake;
  logic [2:0] wake_iv;
  logic       stall;
  addr_type   addr_ctrl;
  logic [2:0] iv;
  dout_type   dout_sel;
  logic       sp_dec;
  logic       pc_hi_load;
  logic       pc_lo_load;
  logic       set_i;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef logic [14:0] obs_t;
  obs_t sb[$];

  interrupt_sequencer #(.RESET_IV(3'b111), .NMI_IV(3'b110)) dut (
    .clk(clk), .rst(rst), .start(start), .start_iv(start_iv),
    .wai_mode(wai_mode), .wake(wake), .wake_iv(wake_iv), .stall(stall),
    .addr_ctrl(addr_ctrl), .iv(iv), .dout_sel(dout_sel), .sp_dec(sp_dec),
    .pc_hi_load(pc_hi_load), .pc_lo_load(pc_lo_load), .set_i(set_i),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {addr_ctrl, iv, dout_sel, sp_dec, pc_hi_load, pc_lo_load, set_i, busy, done}
  function automatic obs_t mk(addr_type a, logic [2:0] v, dout_type d,
                              logic sp, logic ph, logic pl, logic si,
                              logic b, logic dn);
    return {a, v, d, sp, ph, pl, si, b, dn};
  endfunction

  function automatic obs_t observe();
    return {addr_ctrl, iv, dout_sel, sp_dec, pc_hi_load, pc_lo_load, set_i, busy, done};
  endfunction

  task automatic exp_stack(input logic [2:0] v, input int n_stall_ixh);
    dout_type seq [7];
    seq = '{pc_lo_dout, pc_hi_dout, ix_lo_dout, ix_hi_dout, acca_dout, accb_dout, cc_dout};
    for (int i = 0; i < 7; i++) begin
      if (i == 3)
        for (int k = 0; k < n_stall_ixh; k++)
          sb.push_back(mk(push_ad, v, ix_hi_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      sb.push_back(mk(push_ad, v, seq[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  task automatic exp_vector(input logic [2:0] v);
    sb.push_back(mk(int_hi_ad, v, md_lo_dout, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(int_lo_ad, v, md_lo_dout, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(idle_ad,   v, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    sb.push_back(mk(idle_ad,   v, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1; start = 1'b0; start_iv = '0; wai_mode = 1'b0;
    wake = 1'b0; wake_iv = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = mk(idle_ad, 3'd0, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (observe() !== e) begin
      bad++;
      $display("FAIL reset_state: got %h expected %h", observe(), e);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_irq1();
    obs_t e;
    int c = 1;
    exp_stack(IRQ1_VEC, 0);
    exp_vector(IRQ1_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = IRQ1_VEC;
    while (sb.size() > 0) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL irq1 cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
  endtask

  task automatic test_reset_entry();
    obs_t e;
    int c = 1;
    exp_vector(RESET_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = RESET_VEC; wai_mode = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1 start = 1'b0; wai_mode = 1'b0;
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL reset_entry cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
  endtask

  task automatic test_wai();
    obs_t e;
    int c = 1;
    exp_stack(SWI_VEC, 0);
    for (int i = 0; i < 20; i++)
      sb.push_back(mk(idle_ad, SWI_VEC, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    exp_vector(OCF_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = SWI_VEC; wai_mode = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1
      start = 1'b0; wai_mode = 1'b0;
      wake = (c == 3) || (c == 27);
      wake_iv = (c == 27) ? OCF_VEC : SCI_VEC;
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL wai cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
    wake = 1'b0;
  endtask

  task automatic test_stall();
    obs_t e;
    int c = 1;
    int spc = 0;
    exp_stack(IRQ1_VEC, 3);
    exp_vector(IRQ1_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = IRQ1_VEC;
    while (sb.size() > 0) begin
      @(posedge clk); #1
      start = 1'b0;
      stall = (c >= 4) && (c <= 6);
      @(negedge clk);
      if (sp_dec === 1'b1) spc++;
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL stall cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
    stall = 1'b0;
    total++;
    if (spc !== 7) begin
      bad++;
      $display("FAIL stall_sp_dec_count: got %0d expected 7", spc);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    int c = 1;
    for (int i = 0; i < 5; i++) begin
      e = (i == 0) ? mk(push_ad, IRQ1_VEC, pc_lo_dout, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0) :
          (i == 1) ? mk(push_ad, IRQ1_VEC, pc_hi_dout, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0) :
          (i == 2) ? mk(push_ad, IRQ1_VEC, ix_lo_dout, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0) :
          (i == 3) ? mk(push_ad, IRQ1_VEC, ix_hi_dout, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0) :
                     mk(push_ad, IRQ1_VEC, acca_dout,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      sb.push_back(e);
    end
    @(posedge clk); #1 start = 1'b1; start_iv = IRQ1_VEC;
    while (sb.size() > 0) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
    #2 rst = 1'b1;
    #1;
    e = mk(idle_ad, 3'd0, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (observe() !== e) begin
      bad++;
      $display("FAIL async_reset_immediate: got %h expected %h", observe(), e);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_stack(NMI_VEC, 0);
    exp_vector(NMI_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = NMI_VEC;
    c = 1;
    while (sb.size() > 0) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL nmi_after_reset cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
  endtask

  task automatic test_ignored_start();
    obs_t e;
    int c = 1;
    int dones = 0;
    exp_stack(IRQ1_VEC, 0);
    exp_vector(IRQ1_VEC);
    sb.push_back(mk(idle_ad, IRQ1_VEC, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1 start = 1'b1; start_iv = IRQ1_VEC;
    while (sb.size() > 0) begin
      @(posedge clk); #1
      start = (c == 2) || (c == 10);
      start_iv = SCI_VEC;
      @(negedge clk);
      if (done === 1'b1) dones++;
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL ignored_start cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
    start = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignored_start_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_start_stall();
    obs_t e;
    int c = 1;
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(idle_ad, IRQ1_VEC, md_lo_dout, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_stack(ICF_VEC, 0);
    exp_vector(ICF_VEC);
    @(posedge clk); #1 start = 1'b1; start_iv = ICF_VEC; stall = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk); #1
      stall = (c < 3);
      start = (c < 4);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (observe() !== e) begin
        bad++;
        $display("FAIL start_stall cycle %0d: got %h expected %h", c, observe(), e);
      end
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_irq1();
    test_reset_entry();
    test_wai();
    test_stall();
    test_async_reset();
    test_ignored_start();
    test_start_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Stand-alone FSM for the 6801 core that performs the exception entry sequence.
  - Stacks the 7-byte machine state: PCL, PCH, IXL, IXH, ACCA, ACCB, CCR.
  - Then fetches the 16-bit vector from {12'hFFF, iv, hi/lo}.
- Drives the address-bus multiplexer's addr_ctrl/iv inputs and emits the data-out select and register-load strobes.
- Serves reset, NMI, SWI, the IRQ sources, and WAI (pre-stack, then wait for wake).

Parameters:
- RESET_IV, 3'b111: vector index that skips stacking (reset entry).
- NMI_IV, 3'b110: vector index used for NMI (priority reference only; no special sequencing).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sequence; sampled only in IDLE
- start_iv  in  3  vector index for the sequence being started
- wai_mode  in  1  with start: stack, then park in WAIT
- wake  in  1  interrupt arrived while in WAIT
- wake_iv  in  3  vector index accompanying wake
- stall  in  1  memory not ready; freeze sequencer
- addr_ctrl  out  addr_type  to bus multiplexer
- iv  out  3  to bus multiplexer vector field
- dout_sel  out  dout_type  selects byte driven on data bus during pushes
- sp_dec  out  1  decrement SP after this push
- pc_hi_load  out  1  load PC[15:8] from data bus
- pc_lo_load  out  1  load PC[7:0] from data bus
- set_i  out  1  set CCR I-bit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- States:
  - IDLE
  - P_PCL, P_PCH, P_IXL, P_IXH, P_A, P_B, P_CC
  - WAIT
  - V_HI, V_LO
  - DONE
- Reset (async, any state): state=IDLE, iv_reg=3'b000. Outputs: addr_ctrl=idle_ad, dout_sel=md_lo_dout, all strobes 0, busy=0, done=0.
- IDLE: addr_ctrl=idle_ad. On start, latch start_iv into iv_reg and wai_reg ← wai_mode.
  - start_iv==RESET_IV: go to V_HI; wai_mode is ignored.
  - Otherwise: go to P_PCL.
- Push states:
  - Each drives addr_ctrl=push_ad, dout_sel equal to its byte, and sp_dec=1.
  - Order: P_PCL→P_PCH→P_IXL→P_IXH→P_A→P_B→P_CC.
  - P_CC exits to WAIT if wai_reg, else to V_HI.
- WAIT:
  - addr_ctrl=idle_ad, busy=1.
  - On wake, latch wake_iv into iv_reg and go to V_HI.
  - Held indefinitely without wake.
- V_HI: addr_ctrl=int_hi_ad, pc_hi_load=1, set_i=1. Next state V_LO.
- V_LO: addr_ctrl=int_lo_ad, pc_lo_load=1. Next state DONE.
- DONE: addr_ctrl=idle_ad, done=1 for one cycle. Next state IDLE; a start in DONE is ignored.
- iv output = iv_reg at all times.
- Outputs are a Moore decode of registered state.
- Latency after start is sampled (cycle 0):
  - Normal entry: P_PCL at cycle 1, V_HI at 8, V_LO at 9, done at 10.
  - Reset entry: V_HI at 1, V_LO at 2, done at 3.
- stall:
  - While high, state does not advance.
  - addr_ctrl, iv and dout_sel are held.
  - sp_dec, pc_hi_load, pc_lo_load, set_i and done are gated to 0, so each strobe fires exactly once, on the cycle stall is low.
  - stall in IDLE or WAIT has no effect other than blocking start/wake acceptance.
- start while busy (any non-IDLE state) is ignored; start_iv is not relatched.
- wake outside WAIT is ignored.
- Simultaneous start and stall in IDLE: not accepted; start must be re-sampled.

Decomposition:
- Shared 6801 types package:
  - addr_type, existing: idle_ad, fetch_ad, read_ad, write_ad, push_ad, pull_ad, int_hi_ad, int_lo_ad.
  - New dout_type: md_lo_dout, pc_lo_dout, pc_hi_dout, ix_lo_dout, ix_hi_dout, acca_dout, accb_dout, cc_dout.
  - New istate_type enum for the states above.
  - Vector-index constants: SCI 0, TOF 1, OCF 2, ICF 3, IRQ1 4, SWI 5, NMI 6, RESET 7.
- Single module; no sub-module. The state-to-output decode is one always_comb.

Test Plan:
- IRQ1: start=1, start_iv=4, stall=0.
  - Cycles 1–7: push_ad with dout_sel PCL..CCR, sp_dec=1 each.
  - Cycle 8: int_hi_ad, iv=4, pc_hi_load=1, set_i=1.
  - Cycle 9: int_lo_ad, pc_lo_load=1.
  - Cycle 10: done=1, then IDLE.
- Reset: start_iv=7 → no push_ad cycles; int_hi_ad at cycle 1 (bus address FFFE), int_lo_ad at cycle 2 (FFFF), done at cycle 3.
- WAI: start_iv=5, wai_mode=1.
  - After P_CC, idle_ad with busy=1 held for 20 cycles.
  - wake=1, wake_iv=2 → next cycle int_hi_ad with iv=2 (FFF4), then int_lo_ad, then done.
- stall=1 for 3 cycles during P_IXH → addr_ctrl stays push_ad and dout_sel stays ix_hi_dout; total sp_dec pulses over the sequence = 7; done is delayed by 3 cycles.
- rst=1 asynchronously mid-P_A → outputs go to idle_ad/strobes 0/busy 0 immediately, without a clock edge. After release, a start with start_iv=6 runs a full NMI sequence.
- start pulses (start_iv=0) during P_PCH and during DONE of an iv=4 sequence → ignored; iv stays 4 and a single done is produced.
